// File: rtl/uart_rx_sampler_if.sv
// uart_rx_sampler_if: groups the serial input, control inputs and sampler outputs of
// uart_rx_sampler into a single bundle.
//   RX_IN        serial line, synchronous to CLK
//   Prescale     oversampling ratio request (8, 16 or 32)
//   enable       runs the edge and bit counters
//   dat_samp_en  allows sample capture
//   edge_cnt     position within the current bit, 1..p_reg
//   bit_cnt      completed bit periods in the frame (saturating)
//   sampled_bit  majority-voted bit value
//   samp_valid   one-cycle pulse when sampled_bit updates
// master drives the line and controls; slave is the sampler itself.
interface uart_rx_sampler_if #(
    parameter int unsigned PRESCALE_W = 6,
    parameter int unsigned BIT_CNT_W  = 5
);
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  enable;
    logic                  dat_samp_en;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  sampled_bit;
    logic                  samp_valid;

    modport master (
        output RX_IN, Prescale, enable, dat_samp_en,
        input  edge_cnt, bit_cnt, sampled_bit, samp_valid
    );

    modport slave (
        input  RX_IN, Prescale, enable, dat_samp_en,
        output edge_cnt, bit_cnt, sampled_bit, samp_valid
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampling bit-timing counter and 3-sample majority voter for a UART
// receiver.
//   CLK  single clock, rising edge
//   RST  asynchronous active-low reset
//   bus  uart_rx_sampler_if.slave (RX_IN, Prescale, enable, dat_samp_en in;
//        edge_cnt, bit_cnt, sampled_bit, samp_valid out)
// Prescale is latched on the rising edge of enable and held for the frame. Each bit spans
// edge_cnt 1..p_reg; samples are taken at the middle three positions.
module uart_rx_sampler #(
    parameter int unsigned PRESCALE_W = 6,
    parameter int unsigned BIT_CNT_W  = 5
) (
    input logic                 CLK,
    input logic                 RST,
    uart_rx_sampler_if.slave    bus
);
    localparam logic [PRESCALE_W-1:0] P8  = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] P16 = PRESCALE_W'(16);
    localparam logic [PRESCALE_W-1:0] P32 = PRESCALE_W'(32);
    localparam logic [PRESCALE_W-1:0] One = PRESCALE_W'(1);

    logic                  r_en_q;
    logic [PRESCALE_W-1:0] r_p_reg;
    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic                  r_s0, r_s1, r_s2;
    logic                  r_sampled_bit;
    logic                  r_samp_valid;

    logic                  w_en_rise;
    logic                  w_p_legal;
    logic [PRESCALE_W-1:0] w_p_new;
    logic [PRESCALE_W-1:0] w_p_cur;
    logic [PRESCALE_W-1:0] w_half;
    logic                  w_wrap;
    logic                  w_cap;
    logic                  w_at_s0, w_at_s1, w_at_s2;
    logic                  w_majority;

    assign w_en_rise = bus.enable & ~r_en_q;
    assign w_p_legal = (bus.Prescale == P8) || (bus.Prescale == P16) || (bus.Prescale == P32);
    assign w_p_new   = w_p_legal ? bus.Prescale : P8;
    // p_reg only updates after the rising-edge cycle, so bypass the fresh value on that cycle.
    assign w_p_cur   = w_en_rise ? w_p_new : r_p_reg;
    assign w_half    = w_p_cur >> 1;
    assign w_wrap    = (r_edge_cnt == w_p_cur);

    // Capture is gated by enable so a sample pending when enable drops is discarded.
    assign w_cap     = bus.enable & bus.dat_samp_en;
    assign w_at_s0   = (r_edge_cnt == w_half - One);
    assign w_at_s1   = (r_edge_cnt == w_half);
    assign w_at_s2   = (r_edge_cnt == w_half + One);
    // Third vote uses the live line, not r_s2, so the result is ready one cycle earlier.
    assign w_majority = (r_s0 & r_s1) | (r_s0 & bus.RX_IN) | (r_s1 & bus.RX_IN);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_en_q  <= 1'b0;
            r_p_reg <= P8;
        end else begin
            r_en_q <= bus.enable;
            if (w_en_rise) begin
                r_p_reg <= w_p_new;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (!bus.enable) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (w_wrap) begin
            r_edge_cnt <= One;
            if (!(&r_bit_cnt)) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end else begin
            r_edge_cnt <= r_edge_cnt + One;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_s0          <= 1'b1;
            r_s1          <= 1'b1;
            r_s2          <= 1'b1;
            r_sampled_bit <= 1'b1;
            r_samp_valid  <= 1'b0;
        end else begin
            r_samp_valid <= 1'b0;
            if (w_cap) begin
                if (w_at_s0) begin
                    r_s0 <= bus.RX_IN;
                end
                if (w_at_s1) begin
                    r_s1 <= bus.RX_IN;
                end
                if (w_at_s2) begin
                    r_s2          <= bus.RX_IN;
                    r_sampled_bit <= w_majority;
                    r_samp_valid  <= 1'b1;
                end
            end
        end
    end

    assign bus.edge_cnt    = r_edge_cnt;
    assign bus.bit_cnt     = r_bit_cnt;
    assign bus.sampled_bit = r_sampled_bit;
    assign bus.samp_valid  = r_samp_valid;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: directed scenarios plus randomized frames for uart_rx_sampler, each
// cycle compared against a frame-position reference model.
module tb_uart_rx_sampler;
    localparam int PW = 6;
    localparam int BW = 5;
    localparam int BitMax = 31;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_rx_sampler_if #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) bus ();

    uart_rx_sampler #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a frame is described only by how many enabled edges have elapsed (m_n) and the
    // ratio latched at its start (m_p); counter values follow from plain division.
    int   m_n;
    int   m_p;
    bit   m_en_prev;
    bit   m_s0, m_s1, m_samp, m_valid;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ec_of(input int n);
        return (n == 0) ? 0 : ((n - 1) % m_p) + 1;
    endfunction

    function automatic int bc_of(input int n);
        int b;
        if (n == 0) return 0;
        b = (n - 1) / m_p;
        return (b > BitMax) ? BitMax : b;
    endfunction

    task automatic model_reset();
        m_n = 0; m_p = 8; m_en_prev = 0;
        m_s0 = 1; m_s1 = 1; m_samp = 1; m_valid = 0;
    endtask

    task automatic model_step();
        int ec, h, ps;
        if (!bus.enable) begin
            m_n     = 0;
            m_valid = 0;
        end else begin
            if (!m_en_prev) begin
                ps  = int'(bus.Prescale);
                m_p = (ps == 8 || ps == 16 || ps == 32) ? ps : 8;
            end
            ec = ec_of(m_n);
            h  = m_p / 2;
            m_valid = 0;
            if (bus.dat_samp_en) begin
                if (ec == h - 1) m_s0 = bus.RX_IN;
                if (ec == h) m_s1 = bus.RX_IN;
                if (ec == h + 1) begin
                    m_samp  = (int'(m_s0) + int'(m_s1) + int'(bus.RX_IN)) >= 2;
                    m_valid = 1;
                end
            end
            m_n++;
        end
        m_en_prev = bus.enable;
    endtask

    // Compare the state left by the previous edge, then drive inputs for the next edge.
    task automatic tick(input logic rx, input logic en, input logic se, input int ps,
                        input logic rst_v);
        @(negedge clk);
        check_val("edge_cnt", 32'(bus.edge_cnt), 32'(ec_of(m_n)));
        check_val("bit_cnt", 32'(bus.bit_cnt), 32'(bc_of(m_n)));
        check_val("sampled_bit", 32'(bus.sampled_bit), 32'(m_samp));
        check_val("samp_valid", 32'(bus.samp_valid), 32'(m_valid));
        rst_n           = rst_v;
        bus.RX_IN       = rx;
        bus.enable      = en;
        bus.dat_samp_en = se;
        bus.Prescale    = ps[PW-1:0];
        if (rst_v) model_step();
        else model_reset();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick(1'b1, 1'b0, 1'b1, 8, 1'b1);
    endtask

    initial begin
        int ec, ps, len, gap;
        logic rx_bit, rx;

        rst_n = 1'b0;
        bus.RX_IN = 1'b1; bus.enable = 1'b0; bus.dat_samp_en = 1'b0; bus.Prescale = PW'(8);
        model_reset();
        tick(1'b1, 1'b0, 1'b0, 8, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 8, 1'b1);

        // Prescale 8, line low.
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b1, 8, 1'b1);
        check_val("p8_sampled_low", 32'(bus.sampled_bit), 32'd0);
        idle(2);

        // Prescale 16, single-cycle glitch at edge_cnt 8 is outvoted.
        for (int i = 0; i < 3 * 16 + 2; i++) begin
            ec = ec_of(m_n);
            tick((m_n > 0 && ec == 8) ? 1'b0 : 1'b1, 1'b1, 1'b1, 16, 1'b1);
        end
        check_val("p16_glitch_majority", 32'(bus.sampled_bit), 32'd1);
        idle(2);

        // Prescale 32, samples 0,1,1 at 15,16,17.
        for (int i = 0; i < 40; i++) begin
            ec = ec_of(m_n);
            tick((m_n > 0 && (ec == 16 || ec == 17)) ? 1'b1 : 1'b0, 1'b1, 1'b1, 32, 1'b1);
        end
        check_val("p32_pattern_011", 32'(bus.sampled_bit), 32'd1);
        idle(2);

        // Mid-frame Prescale change is ignored; back-to-back restart relatches; 12 maps to 8.
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b1, 8, 1'b1);
        for (int i = 0; i < 30; i++) tick(1'b1, 1'b1, 1'b1, 16, 1'b1);
        tick(1'b1, 1'b0, 1'b1, 16, 1'b1);
        for (int i = 0; i < 40; i++) tick(1'b0, 1'b1, 1'b1, 16, 1'b1);
        idle(1);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 1'b1, 12, 1'b1);
        idle(2);

        // Saturation of bit_cnt over 40 bit periods.
        for (int i = 0; i < 40 * 8 + 5; i++) tick(1'($urandom_range(0, 1)), 1'b1, 1'b1, 8, 1'b1);
        check_val("bit_cnt_saturated", 32'(bus.bit_cnt), 32'(BitMax));
        idle(2);

        // Asynchronous reset mid-frame at edge_cnt 5, bit_cnt 3.
        while (m_n < 29) tick(1'b0, 1'b1, 1'b1, 8, 1'b1);
        @(posedge clk); #1;
        check_val("pre_reset_edge", 32'(bus.edge_cnt), 32'd5);
        check_val("pre_reset_bit", 32'(bus.bit_cnt), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        check_val("rst_edge_cnt", 32'(bus.edge_cnt), 32'd0);
        check_val("rst_bit_cnt", 32'(bus.bit_cnt), 32'd0);
        check_val("rst_sampled_bit", 32'(bus.sampled_bit), 32'd1);
        check_val("rst_samp_valid", 32'(bus.samp_valid), 32'd0);
        model_reset();
        tick(1'b0, 1'b1, 1'b1, 16, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 16, 1'b1);
        @(posedge clk); #1;
        check_val("post_reset_edge", 32'(bus.edge_cnt), 32'd1);
        check_val("post_reset_bit", 32'(bus.bit_cnt), 32'd0);
        for (int i = 0; i < 40; i++) tick(1'b0, 1'b1, 1'b1, 8, 1'b1);
        idle(2);

        // Randomized frames: ratios legal and illegal, mid-frame Prescale churn, glitches,
        // sampling gaps and enable drops of 1..3 cycles.
        rx_bit = 1'b1;
        for (int f = 0; f < 30; f++) begin
            case ($urandom_range(0, 5))
                0: ps = 8;
                1: ps = 16;
                2: ps = 32;
                3: ps = 12;
                4: ps = 0;
                default: ps = int'($urandom_range(0, 63));
            endcase
            len = int'($urandom_range(5, 200));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 15) == 0) rx_bit = ~rx_bit;
                rx = rx_bit;
                if ($urandom_range(0, 9) == 0) rx = ~rx;
                if ($urandom_range(0, 19) == 0) ps = int'($urandom_range(0, 63));
                tick(rx, 1'b1, ($urandom_range(0, 9) != 0), ps, 1'b1);
            end
            gap = int'($urandom_range(1, 3));
            for (int i = 0; i < gap; i++) tick(rx_bit, 1'b0, 1'b1, ps, 1'b1);
        end
        tick(1'b1, 1'b0, 1'b1, 8, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
